// File: rtl/sphere_contact_fifo_if.sv
// Contact capture bus from the collision core plus the word-serial readout handshake.
interface sphere_contact_fifo_if;
  logic        done_in;
  logic        ret_in;
  logic [31:0] cx_in;
  logic [31:0] cy_in;
  logic [31:0] cz_in;
  logic [31:0] nx_in;
  logic [31:0] ny_in;
  logic [31:0] nz_in;
  logic [31:0] depth_in;
  logic [31:0] g1_in;
  logic [31:0] g2_in;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic [3:0]  word_idx;

  modport master (
    output done_in, ret_in, cx_in, cy_in, cz_in, nx_in, ny_in, nz_in,
           depth_in, g1_in, g2_in, rd_ready,
    input  rd_data, rd_valid, rd_last, word_idx
  );

  modport slave (
    input  done_in, ret_in, cx_in, cy_in, cz_in, nx_in, ny_in, nz_in,
           depth_in, g1_in, g2_in, rd_ready,
    output rd_data, rd_valid, rd_last, word_idx
  );
endinterface

// File: rtl/sphere_contact_fifo.sv
// Queues sphere-sphere contact records on the core's done edge and streams them
// out as nine 32-bit words per record; tracks hit and drop statistics.
module sphere_contact_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic                  CLK_d,
  input  logic                  rst,
  input  logic                  clear,
  sphere_contact_fifo_if.slave  bus,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned NWORDS   = 9;
  localparam int unsigned WW       = 32;
  localparam logic [3:0]  LAST_IDX = 4'(NWORDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state;
  logic            done_q;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [3:0]      word_idx;
  logic [AW:0]     count_nxt;
  logic [WW-1:0]   mem [DEPTH][NWORDS];

  logic cap;
  logic xfer;
  logic pop;
  logic wr_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign cap   = bus.done_in & ~done_q & bus.ret_in;
  assign xfer  = (state == STREAM) & bus.rd_ready;
  assign pop   = xfer & (word_idx == LAST_IDX);
  // A full FIFO still accepts when the head record leaves in the same cycle
  assign wr_ok = cap & ~clear & (~full | pop);

  assign bus.rd_valid = (state == STREAM);
  assign bus.rd_last  = (state == STREAM) & (word_idx == LAST_IDX);
  assign bus.word_idx = word_idx;
  assign bus.rd_data  = (state == STREAM) ? mem[rd_ptr][word_idx] : '0;

  always_comb begin
    count_nxt = count;
    if (wr_ok & ~pop)
      count_nxt = count + (AW+1)'(1);
    else if (pop & ~wr_ok)
      count_nxt = count - (AW+1)'(1);
  end

  // Record storage: all nine words land together in the capture cycle
  always_ff @(posedge CLK_d) begin
    if (wr_ok) begin
      mem[wr_ptr][0] <= bus.cx_in;
      mem[wr_ptr][1] <= bus.cy_in;
      mem[wr_ptr][2] <= bus.cz_in;
      mem[wr_ptr][3] <= bus.nx_in;
      mem[wr_ptr][4] <= bus.ny_in;
      mem[wr_ptr][5] <= bus.nz_in;
      mem[wr_ptr][6] <= bus.depth_in;
      mem[wr_ptr][7] <= bus.g1_in;
      mem[wr_ptr][8] <= bus.g2_in;
    end
  end

  // Pointers, occupancy, statistics and readout FSM
  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_idx <= '0;
      count    <= '0;
      hit_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      state    <= IDLE;
      done_q   <= bus.done_in;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_idx <= '0;
      count    <= '0;
      hit_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      done_q <= bus.done_in;
      count  <= count_nxt;
      if (cap && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (cap && !wr_ok && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (wr_ok)
        wr_ptr <= wr_ptr + AW'(1);

      case (state)
        IDLE: begin
          if (count != '0)
            state <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            if (word_idx == LAST_IDX) begin
              word_idx <= '0;
              rd_ptr   <= rd_ptr + AW'(1);
              if (count_nxt == '0)
                state <= IDLE;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
